// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding and frame constants.
package uart_pkg;

    // Transmitter sequencing states; START may shortcut to GAP on a failed handshake.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } tx_state_t;

    // Bit period shared with the receiver side.
    localparam int CLKS_PER_BIT_DEFAULT = 13;

    // Payload bits per 8N1 frame.
    localparam int DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO: DEPTH entries of WIDTH bits, head word visible combinationally.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; no reset needed because occupancy gates every read that matters.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fc.sv
// 8N1 UART transmitter with RTS/CTS handshake. Bytes queue in a FIFO; each frame raises
// RTS with the start bit and requires CTS (active low) during the start bit, otherwise the
// attempt is aborted and retried, and after MAX_RETRY failures the head byte is dropped.
module uart_tx_fc
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DEPTH        = 4,
    parameter int MAX_RETRY    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic                   tx,
    output logic                   rts,
    input  logic                   cts,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   abort,
    output logic                   drop,
    output tx_state_t              state_dbg
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] BIT_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(DATA_BITS - 1);

    // Write port: valid/ready, a byte transfers on any rising edge where wr_valid && wr_ready.
    // wr_ready reflects the registered occupancy only, so a full FIFO refuses a push even
    // on the cycle it pops.

    tx_state_t     state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic [RW-1:0] retry_cnt, retry_next;
    logic          cts_meta, cts_sync;
    logic          cts_seen, cts_seen_next;
    logic          tx_next, rts_next, abort_next, drop_next;
    logic          push, pop;
    logic          fifo_full, fifo_empty;
    logic [7:0]    head;
    logic          bit_end;

    assign wr_ready  = !fifo_full;
    assign push      = wr_valid && !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign bit_end   = (timer == BIT_LAST);
    assign state_dbg = state;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Two-flop synchroniser for the asynchronous CTS input; idles high (not clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= cts;
            cts_sync <= cts_meta;
        end
    end

    // State, counters and registered line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            retry_cnt <= '0;
            cts_seen  <= 1'b0;
            tx        <= 1'b1;
            rts       <= 1'b1;
            abort     <= 1'b0;
            drop      <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            retry_cnt <= retry_next;
            cts_seen  <= cts_seen_next;
            tx        <= tx_next;
            rts       <= rts_next;
            abort     <= abort_next;
            drop      <= drop_next;
        end
    end

    // Next-state logic: tx/rts values are those to be driven during the next cycle.
    always_comb begin
        state_next    = state;
        timer_next    = bit_end ? '0 : timer + 1'b1;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        retry_next    = retry_cnt;
        cts_seen_next = cts_seen;
        tx_next       = tx;
        rts_next      = rts;
        abort_next    = 1'b0;
        drop_next     = 1'b0;
        pop           = 1'b0;

        case (state)
            IDLE: begin
                timer_next = '0;
                if (!fifo_empty) begin
                    state_next    = START;
                    tx_next       = 1'b0;
                    rts_next      = 1'b0;
                    shift_next    = head;
                    cts_seen_next = 1'b0;
                end
            end
            START: begin
                if (!cts_sync) cts_seen_next = 1'b1;
                if (bit_end) begin
                    if (cts_seen || !cts_sync) begin
                        state_next   = DATA;
                        retry_next   = '0;
                        bit_idx_next = '0;
                        tx_next      = shift[0];
                    end else begin
                        state_next = GAP;
                        tx_next    = 1'b1;
                        rts_next   = 1'b1;
                        abort_next = 1'b1;
                        if (retry_cnt == RETRY_LAST) begin
                            drop_next  = 1'b1;
                            pop        = 1'b1;
                            retry_next = '0;
                        end else begin
                            retry_next = retry_cnt + 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
                        state_next   = STOP;
                        bit_idx_next = '0;
                        tx_next      = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        shift_next   = {1'b0, shift[7:1]};
                        tx_next      = shift[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = GAP;
                    pop        = 1'b1;
                    rts_next   = 1'b1;
                end
            end
            GAP: begin
                if (bit_end) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                rts_next   = 1'b1;
            end
        endcase
    end

endmodule
